// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, derived totals and sync boundaries for the
// 640x480@60 raster generator.
package vga_timing_pkg;
  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int unsigned HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
  localparam int unsigned VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hs_set;
    logic hs_reset;
    logic vs_set;
    logic vs_reset;
    logic frame_start;
  } strobe_t;
endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle: pixel enable in, sync strobes and raster position out.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic pix_en;
  logic hs_set;
  logic hs_reset;
  logic vs_set;
  logic vs_reset;
  logic video_on;
  cnt_t x;
  cnt_t y;
  logic frame_start;

  modport master (input pix_en, output hs_set, hs_reset, vs_set, vs_reset,
                  video_on, x, y, frame_start);
  modport slave  (output pix_en, input hs_set, hs_reset, vs_set, vs_reset,
                  video_on, x, y, frame_start);
endinterface

// File: rtl/vga_mod_counter.sv
// Modulo-N counter with enable; exposes next-state so strobes can be
// decoded one edge early and registered.
module vga_mod_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned N = 800
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output cnt_t cnt_o,
  output cnt_t nxt_o,
  output logic wrap_o
);
  cnt_t cnt_q, cnt_d;
  logic at_max;

  assign at_max = (cnt_q == cnt_t'(N - 1));
  assign wrap_o = en_i && at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = at_max ? '0 : cnt_q + cnt_t'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;
endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: h/v counters plus registered set/reset strobes for
// external hsync/vsync latches.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input logic            clk,
  input logic            reset,
  vga_sync_gen_if.master vga
);
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  cnt_t    h_cnt, h_nxt, v_cnt, v_nxt;
  logic    h_wrap, v_wrap;
  strobe_t strb_d, strb_q;

  vga_mod_counter #(.N(H_TOTAL)) u_hcnt (
    .clk(clk), .reset(reset), .en_i(vga.pix_en),
    .cnt_o(h_cnt), .nxt_o(h_nxt), .wrap_o(h_wrap)
  );

  vga_mod_counter #(.N(V_TOTAL)) u_vcnt (
    .clk(clk), .reset(reset), .en_i(h_wrap),
    .cnt_o(v_cnt), .nxt_o(v_nxt), .wrap_o(v_wrap)
  );

  // Decode from next-state on ticking edges only, so each strobe lands with
  // the counter value it marks and lasts one clk however slow pix_en is.
  always_comb begin
    strb_d = '0;
    if (vga.pix_en) begin
      strb_d.hs_set      = (h_nxt == cnt_t'(HS_START));
      strb_d.hs_reset    = (h_nxt == cnt_t'(HS_END));
      strb_d.vs_set      = h_wrap && (v_nxt == cnt_t'(VS_START));
      strb_d.vs_reset    = h_wrap && (v_nxt == cnt_t'(VS_END));
      strb_d.frame_start = v_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) strb_q <= '0;
    else       strb_q <= strb_d;
  end

  assign vga.hs_set      = strb_q.hs_set;
  assign vga.hs_reset    = strb_q.hs_reset;
  assign vga.vs_set      = strb_q.vs_set;
  assign vga.vs_reset    = strb_q.vs_reset;
  assign vga.frame_start = strb_q.frame_start;
  assign vga.x           = h_cnt;
  assign vga.y           = v_cnt;
  assign vga.video_on    = (h_cnt < cnt_t'(H_ACTIVE)) && (v_cnt < cnt_t'(V_ACTIVE));
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size instance for horizontal timing, a short-line
// instance (16 px/line, default vertical) for vertical and frame timing.
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic reset;
  logic pix_en;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if ifa ();
  vga_sync_gen_if ifb ();
  assign ifa.pix_en = pix_en;
  assign ifb.pix_en = pix_en;

  vga_sync_gen u_a (.clk(clk), .reset(reset), .vga(ifa));

  vga_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(4), .H_BP(2)) u_b (
    .clk(clk), .reset(reset), .vga(ifb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input bit sel, input int tx, input int ty, input int budget);
    int n = 0;
    while (!(int'(sel ? ifb.x : ifa.x) == tx && int'(sel ? ifb.y : ifa.y) == ty) && n < budget) begin
      step();
      n++;
    end
    chk("run_to_x", sel ? ifb.x : ifa.x, tx);
    chk("run_to_y", sel ? ifb.y : ifa.y, ty);
  endtask

  function automatic int strb_a();
    return int'(ifa.hs_set) + int'(ifa.hs_reset) + int'(ifa.vs_set)
         + int'(ifa.vs_reset) + int'(ifa.frame_start);
  endfunction

  initial begin
    int sc;
    int n_hs;
    int x_at;
    int n;

    reset  = 1'b1;
    pix_en = 1'b1;
    repeat (3) step();
    chk("rst_x", ifa.x, 0);
    chk("rst_y", ifa.y, 0);
    chk("rst_von", ifa.video_on, 1);
    chk("rst_fs", ifa.frame_start, 0);
    chk("rst_strb", strb_a(), 0);

    // line 0: hsync strobes at 656 and 752
    reset = 1'b0;
    step();
    chk("first_tick_x", ifa.x, 1);
    run_to(0, 655, 0, 1000);
    chk("hs_set_pre", ifa.hs_set, 0);
    step();
    chk("hs_set_656", ifa.hs_set, 1);
    chk("hs_rst_656", ifa.hs_reset, 0);
    step();
    chk("hs_set_657", ifa.hs_set, 0);
    run_to(0, 751, 0, 1000);
    step();
    chk("hs_rst_752", ifa.hs_reset, 1);
    chk("hs_set_752", ifa.hs_set, 0);
    step();
    chk("hs_rst_753", ifa.hs_reset, 0);

    // freeze at 655 for 10 clks, then one tick into 656
    run_to(0, 655, 1, 1000);
    pix_en = 1'b0;
    sc = 0;
    repeat (10) begin
      step();
      sc += strb_a();
    end
    chk("frz_x", ifa.x, 655);
    chk("frz_y", ifa.y, 1);
    chk("frz_strb", sc, 0);
    pix_en = 1'b1;
    step();
    chk("unfrz_x", ifa.x, 656);
    chk("unfrz_hs_set", ifa.hs_set, 1);
    pix_en = 1'b0;
    step();
    chk("hold_x", ifa.x, 656);
    chk("hold_hs_set", ifa.hs_set, 0);

    // half-rate pix_en across the hsync start
    pix_en = 1'b1;
    run_to(0, 650, 2, 1000);
    n_hs = 0;
    x_at = 0;
    for (int i = 0; i < 20; i++) begin
      pix_en = (i % 2 == 0);
      step();
      if (ifa.hs_set) begin
        n_hs++;
        x_at = ifa.x;
      end
    end
    chk("half_hs_cnt", n_hs, 1);
    chk("half_hs_x", x_at, 656);
    chk("half_end_x", ifa.x, 660);

    // reset during hsync
    pix_en = 1'b1;
    run_to(0, 700, 2, 1000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_x", ifa.x, 0);
    chk("midrst_y", ifa.y, 0);
    chk("midrst_hs_rst", ifa.hs_reset, 0);
    chk("midrst_strb", strb_a(), 0);
    chk("midrst_von", ifa.video_on, 1);

    // vertical timing on the short-line instance (started at (0,0) by reset)
    run_to(1, 7, 479, 9000);
    chk("b_von_7_479", ifb.video_on, 1);
    run_to(1, 15, 479, 100);
    chk("b_von_15_479", ifb.video_on, 0);
    step();
    chk("b_wrap_x", ifb.x, 0);
    chk("b_wrap_y", ifb.y, 480);
    chk("b_von_480", ifb.video_on, 0);
    chk("b_vs_set_480", ifb.vs_set, 0);
    run_to(1, 15, 489, 1000);
    step();
    chk("b_vs_set_y", ifb.y, 490);
    chk("b_vs_set", ifb.vs_set, 1);
    chk("b_vs_rst_490", ifb.vs_reset, 0);
    step();
    chk("b_vs_set_off", ifb.vs_set, 0);
    run_to(1, 15, 491, 1000);
    step();
    chk("b_vs_rst", ifb.vs_reset, 1);
    chk("b_vs_set_492", ifb.vs_set, 0);
    step();
    chk("b_vs_rst_off", ifb.vs_reset, 0);
    run_to(1, 15, 524, 1000);
    chk("b_fs_pre", ifb.frame_start, 0);
    step();
    chk("b_fs_x", ifb.x, 0);
    chk("b_fs_y", ifb.y, 0);
    chk("b_fs", ifb.frame_start, 1);
    chk("b_fs_von", ifb.video_on, 1);

    // ticks per frame: 16 * 525
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) chk("b_fs_width", ifb.frame_start, 0);
    end while (!ifb.frame_start && n < 9000);
    chk("b_frame_ticks", n, 8400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset; sampled on the clk rising edge only.
REQ-003 SHALL have port: pix_en  input  1  pixel-tick enable; counters advance only on clk edges where pix_en=1.
REQ-004 SHALL have port: hs_set  output  1  one-clk strobe marking the start of the horizontal sync interval; drives the set input of the hsync LATCH.
REQ-005 SHALL have port: hs_reset  output  1  one-clk strobe marking the end of the horizontal sync interval; drives the reset input of the hsync LATCH.
REQ-006 SHALL have ports: vs_set, vs_reset  output  1 each  the same strobes for the vsync LATCH.
REQ-007 SHALL have port: video_on  output  1  high while (h_cnt,v_cnt) is inside the 640x480 active area.
REQ-008 SHALL have ports: x  output  10, y  output  10  current h_cnt / v_cnt values.
REQ-009 SHALL have port: frame_start  output  1  one-clk strobe on frame wrap.
REQ-010 SHALL use parameters (name, default, meaning): H_ACTIVE 640 visible pixels; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch; V_ACTIVE 480; V_FP 10; V_SYNC 2; V_BP 33.

Function
REQ-011 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL=800), incrementing by 1 on each clk edge with pix_en=1.
REQ-012 When h_cnt=H_TOTAL-1 and pix_en=1, h_cnt SHALL wrap to 0 and v_cnt SHALL increment in the same edge.
REQ-013 v_cnt SHALL count 0..V_TOTAL-1 (V_TOTAL=525); at h_cnt=799, v_cnt=524, pix_en=1 both SHALL wrap to 0 in the same edge.
REQ-014 Counters SHALL hold their value on edges with pix_en=0; no strobe SHALL assert on such edges.
REQ-015 x, y, video_on SHALL be combinational decodes of the counter registers (zero latency); video_on = (h_cnt<640) AND (v_cnt<480).
REQ-016 hs_set SHALL be high for exactly one clk cycle, namely the cycle in which h_cnt first holds H_ACTIVE+H_FP (656).
REQ-017 hs_reset SHALL be high for exactly one clk cycle, the cycle in which h_cnt first holds 656+H_SYNC (752).
REQ-018 vs_set SHALL be high for exactly one clk cycle when (v_cnt,h_cnt) first holds (490,0); vs_reset likewise at (492,0).
REQ-019 frame_start SHALL be high for exactly one clk cycle when (v_cnt,h_cnt) becomes (0,0) through wrap-around.
REQ-020 Strobes SHALL be registered (decoded from next-state with pix_en=1), so they are glitch-free and aligned with the counter value they mark.
REQ-021 hs_set and hs_reset SHALL never be high in the same cycle; likewise vs_set and vs_reset.
REQ-022 Strobe width SHALL be one clk cycle regardless of pix_en duty cycle.
REQ-023 Counter arithmetic SHALL be 10-bit unsigned; no value outside the ranges of REQ-011/REQ-013 SHALL ever be held.

Reset
REQ-024 On a clk edge with reset=1: h_cnt=0, v_cnt=0, all strobes=0; reset SHALL take priority over pix_en.
REQ-025 After reset: x=0, y=0, video_on=1, frame_start=0 (reset entry is not a wrap).
REQ-026 Reset asserted mid-line or mid-sync SHALL return to (0,0) on the next edge with no hs_reset/vs_reset issued; downstream latches are reset by the system reset.

Structure
REQ-027 Timing parameter defaults, derived H_TOTAL/V_TOTAL and sync boundary constants SHALL reside in shared package vga_timing_pkg.
REQ-028 One sub-module vga_mod_counter (modulo-N counter with enable, wrap output) SHALL be instantiated twice (horizontal, vertical).
REQ-029 No combinational path SHALL exist from pix_en to any strobe output.

Verification
REQ-030 reset 3 cycles, pix_en=1 constant -> x=0,y=0,video_on=1; hs_set high exactly at x=656, hs_reset at x=752, one cycle each.
REQ-031 pix_en=1 every 2nd clk -> counters advance every 2 clks; hs_set still exactly 1 clk wide at x=656.
REQ-032 Run to (799,479) -> next tick (0,480), video_on=0; vs_set at (490,0), vs_reset at (492,0).
REQ-033 Run to (799,524) -> next tick (0,0), frame_start=1 for one clk; total 420000 ticks per frame.
REQ-034 Assert reset at x=700 (during hsync) -> next edge x=0,y=0, no hs_reset pulse, all strobes 0.
REQ-035 pix_en=0 for 10 clks at x=655 -> counters frozen, no strobes; first pix_en tick -> x=656 with hs_set.
